// File: rtl/processing_unit_pkg.sv
// Shared encodings for the processing_unit_seq datapath: ALU ops, operand
// select codes, sequencer states and condition-code helpers.
package processing_unit_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_AND  = 3'b001,
    ALU_NOT  = 3'b010,
    ALU_PASS = 3'b011,
    ALU_MUL  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_SRA  = 3'b111
  } aluk_e;

  typedef enum logic [1:0] {
    DR_IR119 = 2'b00,
    DR_R6    = 2'b01,
    DR_R7    = 2'b10,
    DR_R0    = 2'b11
  } drmux_e;

  typedef enum logic [1:0] {
    SR1_IR119 = 2'b00,
    SR1_IR86  = 2'b01,
    SR1_R6    = 2'b10,
    SR1_R0    = 2'b11
  } sr1mux_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [2:0] NZP_RESET = 3'b010;
  localparam int unsigned R6_IDX = 6;
  localparam int unsigned R7_IDX = 7;

  // One-hot {N,Z,P} from the sign bit and a zero flag.
  function automatic logic [2:0] nzp_from(input logic msb, input logic is_zero);
    logic [2:0] nzp;
    if (is_zero) begin
      nzp = 3'b010;
    end else if (msb) begin
      nzp = 3'b100;
    end else begin
      nzp = 3'b001;
    end
    return nzp;
  endfunction

endpackage

// File: rtl/register_file_seq.sv
// General-purpose register file: async clear, one synchronous write port and
// two asynchronous read ports (reads return the pre-write value on a write edge).
module register_file_seq #(
  parameter int WIDTH     = 16,
  parameter int REG_COUNT = 8,
  parameter int AW        = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr1,
  output logic [WIDTH-1:0] o_rdata1,
  input  logic [AW-1:0]    i_raddr2,
  output logic [WIDTH-1:0] o_rdata2
);

  // Fully decoded so every AW-bit address is backed even when REG_COUNT < 8.
  localparam int DEPTH = (1 << AW);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Register storage: cleared on reset, written on i_we.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = mem_q[i_raddr1];
  assign o_rdata2 = mem_q[i_raddr2];

endmodule

// File: rtl/processing_unit_seq.sv
// LC-3 style register-file/ALU datapath with a registered result, a
// start/busy/done handshake, a shift-add multiplier and NZP generation.
module processing_unit_seq
  import processing_unit_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REG_COUNT = 8,
  parameter int IMM_W     = 5
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_LD_REG,
  input  logic             i_LD_CC,
  input  logic [1:0]       i_DRMUX,
  input  logic [1:0]       i_SR1MUX,
  input  logic [15:0]      i_IR,
  input  logic [2:0]       i_ALUK,
  input  logic             i_START,
  input  logic [WIDTH-1:0] i_bus,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [WIDTH-1:0] o_ToBus,
  output logic [2:0]       o_NZP
);

  localparam int AW = ($clog2(REG_COUNT) < 3) ? 3 : $clog2(REG_COUNT);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] to_bus_q, to_bus_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       nzp_q, nzp_d;

  logic [AW-1:0]    dr_addr_s, sr1_addr_s, sr2_addr_s;
  logic [WIDTH-1:0] sr1_s, rd2_s, sr2_s, imm_s, alu_s, acc_sum_s;
  logic [SW-1:0]    shamt_s;
  logic             unused_s;

  assign unused_s = ^i_IR[15:12];

  // Destination register select.
  always_comb begin
    dr_addr_s = '0;
    case (drmux_e'(i_DRMUX))
      DR_IR119: dr_addr_s = AW'(i_IR[11:9]);
      DR_R6:    dr_addr_s = AW'(R6_IDX);
      DR_R7:    dr_addr_s = AW'(R7_IDX);
      DR_R0:    dr_addr_s = '0;
      default:  dr_addr_s = '0;
    endcase
  end

  // First source register select.
  always_comb begin
    sr1_addr_s = '0;
    case (sr1mux_e'(i_SR1MUX))
      SR1_IR119: sr1_addr_s = AW'(i_IR[11:9]);
      SR1_IR86:  sr1_addr_s = AW'(i_IR[8:6]);
      SR1_R6:    sr1_addr_s = AW'(R6_IDX);
      SR1_R0:    sr1_addr_s = '0;
      default:   sr1_addr_s = '0;
    endcase
  end

  assign sr2_addr_s = AW'(i_IR[2:0]);
  assign imm_s      = {{(WIDTH-IMM_W){i_IR[IMM_W-1]}}, i_IR[IMM_W-1:0]};
  assign sr2_s      = i_IR[5] ? imm_s : rd2_s;
  assign shamt_s    = sr2_s[SW-1:0];

  register_file_seq #(
    .WIDTH    (WIDTH),
    .REG_COUNT(REG_COUNT),
    .AW       (AW)
  ) u_rf (
    .i_clk   (i_CLK),
    .i_rst_n (i_RST_N),
    .i_we    (i_LD_REG),
    .i_waddr (dr_addr_s),
    .i_wdata (i_bus),
    .i_raddr1(sr1_addr_s),
    .o_rdata1(sr1_s),
    .i_raddr2(sr2_addr_s),
    .o_rdata2(rd2_s)
  );

  // Single-cycle ALU; MUL is handled by the sequencer instead.
  always_comb begin
    alu_s = '0;
    case (aluk_e'(i_ALUK))
      ALU_ADD:  alu_s = sr1_s + sr2_s;
      ALU_AND:  alu_s = sr1_s & sr2_s;
      ALU_NOT:  alu_s = ~sr1_s;
      ALU_PASS: alu_s = sr1_s;
      ALU_SHL:  alu_s = sr1_s << shamt_s;
      ALU_SHR:  alu_s = sr1_s >> shamt_s;
      ALU_SRA:  alu_s = WIDTH'($signed(sr1_s) >>> shamt_s);
      ALU_MUL:  alu_s = '0;
      default:  alu_s = '0;
    endcase
  end

  assign acc_sum_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Sequencer next state: launch, shift-add iterations and result load.
  always_comb begin
    state_d  = state_q;
    to_bus_d = to_bus_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_START) begin
          if (aluk_e'(i_ALUK) == ALU_MUL) begin
            mcand_d  = sr1_s;
            mplier_d = sr2_s;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_EXEC;
          end else begin
            to_bus_d = alu_s;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        acc_d    = acc_sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          to_bus_d = acc_sum_s;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Condition codes follow the bus whenever i_LD_CC is asserted.
  always_comb begin
    if (i_LD_CC) begin
      nzp_d = nzp_from(i_bus[WIDTH-1], i_bus == '0);
    end else begin
      nzp_d = nzp_q;
    end
  end

  // State, result, multiplier and condition-code registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= ST_IDLE;
      to_bus_q <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      nzp_q    <= NZP_RESET;
    end else begin
      state_q  <= state_d;
      to_bus_q <= to_bus_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nzp_q    <= nzp_d;
    end
  end

  assign o_BUSY  = (state_q != ST_IDLE);
  assign o_DONE  = (state_q == ST_DONE);
  assign o_ToBus = to_bus_q;
  assign o_NZP   = nzp_q;

endmodule

// File: tb/tb_processing_unit_seq.sv
// Scoreboard bench: each START pushes its expected result, and a negedge
// monitor pops and compares whenever o_DONE is presented.
module tb_processing_unit_seq;

  localparam logic [2:0] OP_ADD = 3'b000, OP_AND = 3'b001, OP_NOT = 3'b010,
                         OP_PASS = 3'b011, OP_MUL = 3'b100, OP_SHL = 3'b101,
                         OP_SHR = 3'b110, OP_SRA = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_reg = 1'b0, ld_cc = 1'b0, start = 1'b0;
  logic [1:0]  drmux = 2'b00, sr1mux = 2'b00;
  logic [15:0] ir = 16'h0000, bus = 16'h0000;
  logic [2:0]  aluk = 3'b000;
  logic        busy, done;
  logic [15:0] tobus;
  logic [2:0]  nzp;

  int          total = 0;
  int          passed = 0;
  logic [15:0] sb[$];

  processing_unit_seq #(.WIDTH(16), .REG_COUNT(8), .IMM_W(5)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LD_REG(ld_reg), .i_LD_CC(ld_cc),
    .i_DRMUX(drmux), .i_SR1MUX(sr1mux), .i_IR(ir), .i_ALUK(aluk),
    .i_START(start), .i_bus(bus), .o_BUSY(busy), .o_DONE(done),
    .o_ToBus(tobus), .o_NZP(nzp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every DONE cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        check("tobus", {16'h0, tobus}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ir_rr(input logic [2:0] s1, input logic [2:0] s2);
    return {4'b0001, 3'b000, s1, 1'b0, 2'b00, s2};
  endfunction

  function automatic logic [15:0] ir_ri(input logic [2:0] s1, input logic [4:0] imm);
    return {4'b0001, 3'b000, s1, 1'b1, imm};
  endfunction

  task automatic wr_reg(input logic [1:0] dm, input logic [2:0] r, input logic [15:0] v);
    drmux = dm; ir = {4'h0, r, 9'h000}; bus = v; ld_reg = 1'b1;
    tick();
    ld_reg = 1'b0; drmux = 2'b00;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] s1m, input logic [15:0] irv,
                       input logic [15:0] exp);
    aluk = op; sr1mux = s1m; ir = irv; start = 1'b1;
    sb.push_back(exp);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      tick();
    end
    check("idle_timeout", {31'h0, busy}, 32'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] s1m, input logic [15:0] irv,
                     input logic [15:0] exp);
    issue(op, s1m, irv, exp);
    wait_idle();
  endtask

  initial begin
    int c, busy_cnt, done_at;

    // Reset state
    repeat (2) tick();
    check("rst_busy",  {31'h0, busy}, 32'd0);
    check("rst_done",  {31'h0, done}, 32'd0);
    check("rst_tobus", {16'h0, tobus}, 32'h0000);
    check("rst_nzp",   {29'h0, nzp}, 32'b010);
    rst_n = 1'b1;
    tick();

    // ADD register/register
    wr_reg(2'b00, 3'd1, 16'h0005);
    wr_reg(2'b00, 3'd2, 16'hFFFD);
    run(OP_ADD, 2'b01, ir_rr(3'd1, 3'd2), 16'h0002);

    // ADD immediate, and wrap-around
    wr_reg(2'b00, 3'd1, 16'h7FFF);
    run(OP_ADD, 2'b01, ir_ri(3'd1, 5'b10000), 16'h7FEF);
    wr_reg(2'b00, 3'd3, 16'hFFFF);
    run(OP_ADD, 2'b01, ir_ri(3'd3, 5'b00001), 16'h0000);

    // Special DR/SR1 selections: R6, R7, R0
    wr_reg(2'b01, 3'd0, 16'h0ABC);
    run(OP_PASS, 2'b10, ir_rr(3'd0, 3'd0), 16'h0ABC);
    wr_reg(2'b10, 3'd0, 16'h1234);
    run(OP_ADD, 2'b11, ir_rr(3'd0, 3'd7), 16'h1234);
    wr_reg(2'b11, 3'd0, 16'h0003);
    run(OP_ADD, 2'b11, ir_ri(3'd0, 5'b00001), 16'h0004);

    // MUL: latency, busy length, ignored START, register write while busy
    wr_reg(2'b00, 3'd1, 16'h0013);
    wr_reg(2'b00, 3'd2, 16'h0007);
    issue(OP_MUL, 2'b01, ir_rr(3'd1, 3'd2), 16'h0085);
    c = 1; busy_cnt = 0; done_at = 0;
    while (busy && c < 40) begin
      busy_cnt++;
      if (done) done_at = c;
      if (c == 3) begin
        drmux = 2'b00; ir = {4'h0, 3'd1, 9'h000}; bus = 16'h0000; ld_reg = 1'b1;
      end else if (c == 4) begin
        ld_reg = 1'b0;
      end
      if (c == 6) begin
        aluk = OP_ADD; start = 1'b1;
      end else if (c == 7) begin
        start = 1'b0;
      end
      tick();
      c++;
    end
    check("mul_busy_cycles", busy_cnt, 32'd17);
    check("mul_done_cycle", done_at, 32'd17);
    run(OP_PASS, 2'b01, ir_rr(3'd1, 3'd0), 16'h0000);

    // Shifts, including a masked shift field
    wr_reg(2'b00, 3'd1, 16'h8001);
    run(OP_SHL, 2'b01, ir_ri(3'd1, 5'b00100), 16'h0010);
    run(OP_SHR, 2'b01, ir_ri(3'd1, 5'b00100), 16'h0800);
    run(OP_SRA, 2'b01, ir_ri(3'd1, 5'b00100), 16'hF800);
    run(OP_SHL, 2'b01, ir_ri(3'd1, 5'b10100), 16'h0010);
    wr_reg(2'b00, 3'd2, 16'h0014);
    run(OP_SHR, 2'b01, ir_rr(3'd1, 3'd2), 16'h0800);
    run(OP_AND, 2'b01, ir_ri(3'd1, 5'b11111), 16'h8001);
    run(OP_NOT, 2'b01, ir_rr(3'd1, 3'd0), 16'h7FFE);

    // Condition codes, with a simultaneous register write
    ld_cc = 1'b1;
    wr_reg(2'b00, 3'd4, 16'h8000);
    ld_cc = 1'b0;
    check("nzp_neg", {29'h0, nzp}, 32'b100);
    run(OP_PASS, 2'b01, ir_rr(3'd4, 3'd0), 16'h8000);
    ld_cc = 1'b1; bus = 16'h0000; tick(); ld_cc = 1'b0;
    check("nzp_zero", {29'h0, nzp}, 32'b010);
    ld_cc = 1'b1; bus = 16'h0042; tick(); ld_cc = 1'b0;
    check("nzp_pos", {29'h0, nzp}, 32'b001);

    // Reset in the middle of a MUL
    wr_reg(2'b00, 3'd1, 16'h0013);
    issue(OP_MUL, 2'b01, ir_rr(3'd1, 3'd2), 16'h0000);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy",  {31'h0, busy}, 32'd0);
    check("abort_done",  {31'h0, done}, 32'd0);
    check("abort_tobus", {16'h0, tobus}, 32'h0000);
    check("abort_nzp",   {29'h0, nzp}, 32'b010);
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    check("abort_idle", {31'h0, busy}, 32'd0);

    // START on the same edge as a write to the source register sees the old value
    wr_reg(2'b00, 3'd5, 16'h1111);
    drmux = 2'b00; ir = {4'h0, 3'd5, 3'd5, 6'b000000}; bus = 16'h2222; ld_reg = 1'b1;
    aluk = OP_PASS; sr1mux = 2'b01; start = 1'b1;
    sb.push_back(16'h1111);
    tick();
    ld_reg = 1'b0; start = 1'b0;
    wait_idle();
    run(OP_PASS, 2'b01, ir_rr(3'd5, 3'd0), 16'h2222);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
